// File: rtl/if_fetch_pipe_if.sv
// Fetch-stage bundle: redirect/hazard controls, instruction-memory load port and the
// registered IF/ID outputs. The master drives controls; the slave is the fetch stage.
interface if_fetch_pipe_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned IMEM_DEPTH = 64
);
    localparam int unsigned AW = $clog2(IMEM_DEPTH);

    logic            PCSrc;
    logic [XLEN-1:0] PC_branch;
    logic            stall;
    logic            flush;
    logic            load_en;
    logic [AW-1:0]   load_addr;
    logic [XLEN-1:0] load_data;

    logic [XLEN-1:0] PC_plus_four_out;
    logic [XLEN-1:0] instruction_out;
    logic            valid_out;
    logic            fetch_fault_out;
    logic [31:0]     fetch_count;

    modport master (
        output PCSrc, PC_branch, stall, flush, load_en, load_addr, load_data,
        input  PC_plus_four_out, instruction_out, valid_out, fetch_fault_out, fetch_count
    );

    modport slave (
        input  PCSrc, PC_branch, stall, flush, load_en, load_addr, load_data,
        output PC_plus_four_out, instruction_out, valid_out, fetch_fault_out, fetch_count
    );
endinterface

// File: rtl/if_fetch_pipe.sv
// Instruction-fetch stage: PC register, word-addressed instruction memory with a load
// port, and the IF/ID pipeline register with stall/flush/redirect handling.
module if_fetch_pipe #(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     IMEM_DEPTH = 64,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input logic            clock,
    input logic            reset_n,
    if_fetch_pipe_if.slave bus
);
    localparam int unsigned AW = $clog2(IMEM_DEPTH);

    // Memory contents survive reset; only the time-zero initialiser clears them.
    logic [XLEN-1:0] r_mem [IMEM_DEPTH] = '{default: '0};

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc4;
    logic [XLEN-1:0] r_instr;
    logic            r_valid;
    logic            r_fault;
    logic [31:0]     r_count;

    logic [XLEN-1:0] w_pc_plus4;
    logic            w_misaligned;
    logic            w_out_of_range;
    logic            w_fault;
    logic [XLEN-1:0] w_word;
    logic            w_capture;
    logic [XLEN-1:0] w_pc_next;

    always_comb begin
        w_pc_plus4     = r_pc + {{(XLEN-3){1'b0}}, 3'd4};
        w_misaligned   = |r_pc[1:0];
        w_out_of_range = |(r_pc >> (AW + 2));
        w_fault        = w_misaligned | w_out_of_range;
        w_word         = w_fault ? '0 : r_mem[r_pc[AW+1:2]];
        w_capture      = !bus.flush && !bus.stall;
    end

    // Redirect wins over stall so a taken branch is never lost while the front end is held.
    always_comb begin
        w_pc_next = r_pc;
        if (bus.PCSrc) begin
            w_pc_next = bus.PC_branch;
        end else if (!bus.stall) begin
            w_pc_next = w_pc_plus4;
        end
    end

    always_ff @(posedge clock) begin
        if (bus.load_en) begin
            r_mem[bus.load_addr] <= bus.load_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc4   <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
        end else if (bus.flush) begin
            r_pc4   <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
        end else if (!bus.stall) begin
            r_pc4   <= w_pc_plus4;
            r_instr <= w_word;
            r_valid <= 1'b1;
            r_fault <= w_fault;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (w_capture && (r_count != 32'hFFFF_FFFF)) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign bus.PC_plus_four_out = r_pc4;
    assign bus.instruction_out  = r_instr;
    assign bus.valid_out        = r_valid;
    assign bus.fetch_fault_out  = r_fault;
    assign bus.fetch_count      = r_count;
endmodule

// File: tb/tb_if_fetch_pipe.sv
// Self-checking bench for if_fetch_pipe: directed scenarios plus randomized control traffic
// compared against a behavioural fetch-stage model.
module tb_if_fetch_pipe;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    if_fetch_pipe_if #(.XLEN(XLEN), .IMEM_DEPTH(DEPTH)) bus ();

    if_fetch_pipe #(
        .XLEN      (XLEN),
        .IMEM_DEPTH(DEPTH),
        .RESET_PC  (32'h0)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc;
    logic [31:0] m_pc4;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_fault;
    logic [31:0] m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_pc4   = 32'h0;
        m_instr = 32'h0;
        m_valid = 1'b0;
        m_fault = 1'b0;
        m_cnt   = 32'h0;
    endtask

    // Applies one rising edge to the model using the inputs as they stood before it.
    task automatic model_edge();
        logic        fault;
        logic [31:0] word;
        if (reset_n) begin
            fault = (m_pc % 4 != 0) || (m_pc / 4 >= DEPTH);
            word  = fault ? 32'h0 : m_mem[AW'(m_pc / 4)];
            if (bus.flush) begin
                m_pc4 = 0; m_instr = 0; m_valid = 0; m_fault = 0;
            end else if (!bus.stall) begin
                m_pc4 = m_pc + 4; m_instr = word; m_valid = 1; m_fault = fault;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            end
            if (bus.PCSrc) m_pc = bus.PC_branch;
            else if (!bus.stall) m_pc = m_pc + 4;
        end
        if (bus.load_en) m_mem[bus.load_addr] = bus.load_data;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".pc4"},   64'(bus.PC_plus_four_out), 64'(m_pc4));
        check({tag, ".instr"}, 64'(bus.instruction_out),  64'(m_instr));
        check({tag, ".valid"}, 64'(bus.valid_out),        64'(m_valid));
        check({tag, ".fault"}, 64'(bus.fetch_fault_out),  64'(m_fault));
        check({tag, ".cnt"},   64'(bus.fetch_count),      64'(m_cnt));
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic drive(input logic pcsrc, input logic [31:0] br, input logic st,
                         input logic fl);
        bus.PCSrc     = pcsrc;
        bus.PC_branch = br;
        bus.stall     = st;
        bus.flush     = fl;
    endtask

    task automatic pulse_reset(input string tag);
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        reset_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_target();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, DEPTH - 1)) * 4;
            1:       return 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
            2:       return 32'(4 * DEPTH) + 32'($urandom_range(0, 100)) * 4;
            default: return 32'hFFFF_FFFC;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        model_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        #1;
        compare_all("reset");

        // Preload words 0..3 while reset is held; memory writes are not gated by reset.
        for (int i = 0; i < 4; i++) begin
            bus.load_en   = 1'b1;
            bus.load_addr = AW'(i);
            bus.load_data = 32'h11 * 32'(i + 1);
            step("preload");
        end
        bus.load_en = 1'b0;
        reset_n     = 1'b1;

        for (int i = 0; i < 4; i++) begin
            step("seq");
            check("seq.pc4_k",   64'(bus.PC_plus_four_out), 64'(4 * (i + 1)));
            check("seq.instr_k", 64'(bus.instruction_out),  64'(32'h11 * 32'(i + 1)));
        end
        check("seq.valid_k", 64'(bus.valid_out),   64'd1);
        check("seq.cnt_k",   64'(bus.fetch_count), 64'd4);

        // Stall holds PC and IF/ID after the first capture.
        pulse_reset("rst2");
        step("first");
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step("stall1");
        step("stall2");
        check("stall.pc4_k",   64'(bus.PC_plus_four_out), 64'd4);
        check("stall.instr_k", 64'(bus.instruction_out),  64'h11);
        check("stall.cnt_k",   64'(bus.fetch_count),      64'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step("unstall");
        check("unstall.pc4_k",   64'(bus.PC_plus_four_out), 64'd8);
        check("unstall.instr_k", 64'(bus.instruction_out),  64'h22);

        // Redirect during stall: PC moves, IF/ID held.
        drive(1'b1, 32'h8, 1'b1, 1'b0);
        step("redir_stall");
        check("redir_stall.pc4_k", 64'(bus.PC_plus_four_out), 64'd8);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step("after_redir");
        check("after_redir.pc4_k",   64'(bus.PC_plus_four_out), 64'hC);
        check("after_redir.instr_k", 64'(bus.instruction_out),  64'h33);

        // Flush beats stall.
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        step("flush_stall");
        check("flush.instr_k", 64'(bus.instruction_out), 64'd0);
        check("flush.valid_k", 64'(bus.valid_out),       64'd0);
        check("flush.cnt_k",   64'(bus.fetch_count),     64'd3);

        // Misaligned and out-of-range fetch faults.
        drive(1'b1, 32'h6, 1'b0, 1'b0);
        step("br_mis");
        drive(1'b1, 32'(4 * DEPTH), 1'b0, 1'b0);
        step("fetch_mis");
        check("mis.fault_k", 64'(bus.fetch_fault_out), 64'd1);
        check("mis.instr_k", 64'(bus.instruction_out), 64'd0);
        check("mis.valid_k", 64'(bus.valid_out),       64'd1);
        drive(1'b1, 32'h4, 1'b0, 1'b0);
        step("fetch_oor");
        check("oor.fault_k", 64'(bus.fetch_fault_out), 64'd1);
        check("oor.instr_k", 64'(bus.instruction_out), 64'd0);
        check("oor.valid_k", 64'(bus.valid_out),       64'd1);

        // Write to the word being fetched: capture sees the old value, refetch the new one.
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        bus.load_en   = 1'b1;
        bus.load_addr = AW'(1);
        bus.load_data = 32'hAB;
        step("ld_same");
        check("ld_same.instr_k", 64'(bus.instruction_out), 64'h22);
        bus.load_en = 1'b0;
        drive(1'b1, 32'h4, 1'b0, 1'b0);
        step("ld_redir");
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step("ld_refetch");
        check("ld_refetch.instr_k", 64'(bus.instruction_out), 64'hAB);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 4) == 0, rand_target(), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 5) == 0);
            bus.load_en   = $urandom_range(0, 3) == 0;
            bus.load_addr = AW'($urandom_range(0, DEPTH - 1));
            bus.load_data = $urandom;
            if ($urandom_range(0, 59) == 0) pulse_reset("rnd_rst");
            step("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/if_fetch_pipe.md
IF_FETCH_PIPE -- requirements
Module: if_fetch_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/PC width in bits.
REQ-002 SHALL have parameter IMEM_DEPTH, default 64, meaning instruction memory size in words (power of two, >=2).
REQ-003 SHALL have parameter RESET_PC, default 0, meaning PC value loaded on reset (word aligned).
REQ-004 SHALL have port clock  input  1  rising-edge clock.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port PCSrc  input  1  take redirect this cycle.
REQ-007 SHALL have port PC_branch  input  XLEN  redirect target.
REQ-008 SHALL have port stall  input  1  hold PC and IF/ID register.
REQ-009 SHALL have port flush  input  1  insert bubble into IF/ID register.
REQ-010 SHALL have port load_en  input  1  instruction memory write enable.
REQ-011 SHALL have port load_addr  input  clog2(IMEM_DEPTH)  word index to write.
REQ-012 SHALL have port load_data  input  XLEN  word to write.
REQ-013 SHALL have port PC_plus_four_out  output  XLEN  registered PC+4 of captured instruction.
REQ-014 SHALL have port instruction_out  output  XLEN  registered instruction.
REQ-015 SHALL have port valid_out  output  1  IF/ID register holds a real instruction.
REQ-016 SHALL have port fetch_fault_out  output  1  captured fetch was misaligned or out of range.
REQ-017 SHALL have port fetch_count  output  32  number of instructions accepted into IF/ID.

Function
REQ-018 SHALL hold an XLEN-bit PC register; fetch address = PC.
REQ-019 SHALL read memory combinationally at word index PC>>2; fault if PC[1:0]!=0 or PC>>2 >= IMEM_DEPTH; faulting fetch yields instruction 0.
REQ-020 PC next-state priority: PCSrc -> PC_branch; else stall -> hold; else PC+4 modulo 2^XLEN (wrap at all-ones, no fault from wrap itself).
REQ-021 PCSrc SHALL override stall for the PC update in the same cycle.
REQ-022 IF/ID next-state priority: flush -> bubble (instruction 0, PC_plus_four 0, valid 0, fault 0); else stall -> hold all IF/ID outputs; else capture {PC+4, fetched word, valid 1, fault flag}.
REQ-023 flush SHALL override stall for IF/ID; PCSrc alone SHALL NOT flush IF/ID.
REQ-024 Fetch-to-output latency SHALL be one clock edge.
REQ-025 load_en SHALL write load_data at load_addr on rising edge; a fetch of the same word in that cycle SHALL capture the pre-write contents.
REQ-026 Memory SHALL initialise to all zeros at time zero and SHALL NOT be cleared by reset_n.
REQ-027 fetch_count SHALL increment by 1 on each edge where IF/ID captures (not flush, not stall), including faulting captures, and SHALL saturate at 0xFFFFFFFF.

Reset
REQ-028 reset_n low SHALL asynchronously set PC=RESET_PC, PC_plus_four_out=0, instruction_out=0, valid_out=0, fetch_fault_out=0, fetch_count=0.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL discard the pending action; first edge after deassertion fetches RESET_PC.

Verification
REQ-030 Preload words 0..3 = 0x11,0x22,0x33,0x44, release reset, 4 edges -> outputs (PC+4, instr) = (4,0x11),(8,0x22),(12,0x33),(16,0x44), valid 1, fetch_count 4.
REQ-031 stall high 2 cycles after first capture -> IF/ID outputs unchanged at (4,0x11), PC stays 4, fetch_count unchanged; release -> (8,0x22).
REQ-032 PCSrc=1, PC_branch=0x8, stall=1 same cycle -> PC becomes 0x8, IF/ID held; next edge with stall=0 -> (0xC, word 2).
REQ-033 flush=1 with stall=1 -> instruction_out 0, valid 0, fetch_count unchanged.
REQ-034 PC_branch=0x6 -> next capture instruction 0, fetch_fault_out 1, valid 1; PC_branch=4*IMEM_DEPTH -> same fault response.
REQ-035 load_en writing index 1 = 0xAB while PC=4 -> captured instruction is old word 1; refetch of 4 -> 0xAB.
